// File: rtl/mm_gelu_layer_sched_pkg.sv
// Shared definitions for the mm_gelu layer scheduler: FSM state type and
// derived width helpers used by the scheduler and its parameter file.
package mm_gelu_layer_sched_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN
  } sched_state_e;

  // Layer index width; a single-layer build still gets a 1-bit index.
  function automatic int calc_lw(input int layers);
    return (layers > 1) ? $clog2(layers) : 1;
  endfunction

  // Slice counter width; one extra bit so SLICES itself is representable.
  function automatic int calc_sw(input int slices);
    return $clog2(slices) + 1;
  endfunction

endpackage

// File: rtl/mm_gelu_param_rf.sv
// Per-layer requantization parameter store: one bank for out_m, one for
// out_e. Single write port, one registered read that returns both words.
// Storage is never reset; only the read registers are.
module mm_gelu_param_rf
  import mm_gelu_layer_sched_pkg::*;
#(
  parameter int D_W_ACC = 32,
  parameter int LAYERS  = 12,
  parameter int LW      = calc_lw(LAYERS)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_en,
  input  logic                    wr_sel,
  input  logic [LW-1:0]           wr_addr,
  input  logic [D_W_ACC-1:0]      wr_data,
  input  logic                    rd_en,
  input  logic [LW-1:0]           rd_addr,
  output logic [1:0][D_W_ACC-1:0] rd_data
);

  localparam logic [LW-1:0] LAST_ADDR = LW'(LAYERS - 1);

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_bank
      logic [D_W_ACC-1:0] mem [LAYERS];
      logic [D_W_ACC-1:0] rd_reg;

      // Write port: bank chosen by wr_sel, out-of-range slots are dropped.
      always_ff @(posedge clk) begin
        if (wr_en && (wr_sel == 1'(gi)) && (wr_addr <= LAST_ADDR)) begin
          mem[wr_addr] <= wr_data;
        end
      end

      // Registered read; a same-edge write to this slot returns the old word.
      always_ff @(posedge clk) begin
        if (rst) begin
          rd_reg <= '0;
        end else if (rd_en && (rd_addr <= LAST_ADDR)) begin
          rd_reg <= mem[rd_addr];
        end
      end

      assign rd_data[gi] = rd_reg;
    end
  endgenerate

endmodule

// File: rtl/mm_gelu_layer_sched.sv
// Layer/slice scheduler for the mm_gelu datapath. At the start of each layer
// it streams that layer's out_m/out_e words as single-beat packets, then
// counts output slices and guards each one with a watchdog.
module mm_gelu_layer_sched
  import mm_gelu_layer_sched_pkg::*;
#(
  parameter  int D_W_ACC   = 32,
  parameter  int LAYERS    = 12,
  parameter  int SLICES    = 1,
  parameter  int TIMEOUT_W = 32,
  localparam int LW        = calc_lw(LAYERS),
  localparam int SW        = calc_sw(SLICES)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [LW-1:0]        first_layer,
  input  logic [LW:0]          num_layers,
  input  logic [TIMEOUT_W-1:0] timeout_limit,
  input  logic                 cfg_we,
  input  logic                 cfg_sel,
  input  logic [LW-1:0]        cfg_addr,
  input  logic [D_W_ACC-1:0]   cfg_data,
  output logic                 out_m_tvalid,
  output logic [D_W_ACC-1:0]   out_m_tdata,
  output logic                 out_m_tlast,
  input  logic                 out_m_tready,
  output logic                 out_e_tvalid,
  output logic [D_W_ACC-1:0]   out_e_tdata,
  output logic                 out_e_tlast,
  input  logic                 out_e_tready,
  input  logic                 res_tvalid,
  input  logic                 res_tlast,
  output logic [LW-1:0]        layer,
  output logic [SW-1:0]        slice_cntr,
  output logic                 busy,
  output logic                 done,
  output logic                 err_timeout
);

  localparam logic [LW-1:0] LAST_LAYER = LW'(LAYERS - 1);
  localparam logic [SW-1:0] SLICE_LAST = SW'(SLICES - 1);
  localparam logic [LW:0]   ONE_LAYER  = (LW + 1)'(1);

  sched_state_e         state_reg, state_next;
  logic                 load_entry_reg, load_entry_next;
  logic                 m_valid_reg, m_valid_next;
  logic                 e_valid_reg, e_valid_next;
  logic [LW-1:0]        layer_reg, layer_next;
  logic [SW-1:0]        slice_reg, slice_next;
  logic [LW:0]          remain_reg, remain_next;
  logic [TIMEOUT_W-1:0] wdog_reg, wdog_next;
  logic [TIMEOUT_W-1:0] limit_reg, limit_next;
  logic                 done_reg, done_next;
  logic                 err_reg, err_next;

  logic                    rd_en;
  logic [1:0][D_W_ACC-1:0] rd_data;
  logic                    m_hs;
  logic                    e_hs;
  logic                    slice_evt;

  // The parameter words are fetched once, in the first cycle of LOAD.
  assign rd_en = (state_reg == LOAD) && load_entry_reg;

  mm_gelu_param_rf #(
    .D_W_ACC (D_W_ACC),
    .LAYERS  (LAYERS),
    .LW      (LW)
  ) u_param_rf (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (cfg_we),
    .wr_sel  (cfg_sel),
    .wr_addr (cfg_addr),
    .wr_data (cfg_data),
    .rd_en   (rd_en),
    .rd_addr (layer_reg),
    .rd_data (rd_data)
  );

  assign m_hs      = m_valid_reg & out_m_tready;
  assign e_hs      = e_valid_reg & out_e_tready;
  assign slice_evt = res_tvalid & res_tlast;

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      load_entry_reg <= 1'b0;
      m_valid_reg    <= 1'b0;
      e_valid_reg    <= 1'b0;
      layer_reg      <= '0;
      slice_reg      <= '0;
      remain_reg     <= '0;
      wdog_reg       <= '0;
      limit_reg      <= '0;
      done_reg       <= 1'b0;
      err_reg        <= 1'b0;
    end else begin
      state_reg      <= state_next;
      load_entry_reg <= load_entry_next;
      m_valid_reg    <= m_valid_next;
      e_valid_reg    <= e_valid_next;
      layer_reg      <= layer_next;
      slice_reg      <= slice_next;
      remain_reg     <= remain_next;
      wdog_reg       <= wdog_next;
      limit_reg      <= limit_next;
      done_reg       <= done_next;
      err_reg        <= err_next;
    end
  end

  // Next-state logic: run setup, parameter handshakes, slice/layer
  // accounting and the per-slice watchdog.
  always_comb begin
    state_next      = state_reg;
    load_entry_next = load_entry_reg;
    m_valid_next    = m_valid_reg;
    e_valid_next    = e_valid_reg;
    layer_next      = layer_reg;
    slice_next      = slice_reg;
    remain_next     = remain_reg;
    wdog_next       = wdog_reg;
    limit_next      = limit_reg;
    done_next       = 1'b0;
    err_next        = err_reg;

    case (state_reg)
      IDLE: begin
        if (start) begin
          err_next = 1'b0;
          if (num_layers == '0) begin
            done_next = 1'b1;
          end else begin
            state_next      = LOAD;
            load_entry_next = 1'b1;
            layer_next      = first_layer;
            remain_next     = num_layers;
            limit_next      = timeout_limit;
            slice_next      = '0;
          end
        end
      end

      LOAD: begin
        if (load_entry_reg) begin
          // Read is in flight this cycle; present both beats next cycle.
          load_entry_next = 1'b0;
          m_valid_next    = 1'b1;
          e_valid_next    = 1'b1;
        end else begin
          if (m_hs) m_valid_next = 1'b0;
          if (e_hs) e_valid_next = 1'b0;
          if ((!m_valid_reg || m_hs) && (!e_valid_reg || e_hs)) begin
            state_next = RUN;
            wdog_next  = '0;
          end
        end
      end

      RUN: begin
        if (slice_evt) begin
          // A completion always beats a simultaneous watchdog expiry.
          wdog_next = '0;
          if (slice_reg == SLICE_LAST) begin
            slice_next = '0;
            if (remain_reg == ONE_LAYER) begin
              state_next  = IDLE;
              remain_next = '0;
              done_next   = 1'b1;
            end else begin
              remain_next     = remain_reg - 1'b1;
              layer_next      = (layer_reg == LAST_LAYER) ? '0 : layer_reg + 1'b1;
              state_next      = LOAD;
              load_entry_next = 1'b1;
            end
          end else begin
            slice_next = slice_reg + 1'b1;
          end
        end else if ((limit_reg != '0) && (wdog_reg == limit_reg - 1'b1)) begin
          state_next = IDLE;
          slice_next = '0;
          done_next  = 1'b1;
          err_next   = 1'b1;
        end else begin
          wdog_next = wdog_reg + 1'b1;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign out_m_tvalid = m_valid_reg;
  assign out_m_tlast  = m_valid_reg;
  assign out_m_tdata  = rd_data[0];
  assign out_e_tvalid = e_valid_reg;
  assign out_e_tlast  = e_valid_reg;
  assign out_e_tdata  = rd_data[1];
  assign layer        = layer_reg;
  assign slice_cntr   = slice_reg;
  assign busy         = (state_reg != IDLE);
  assign done         = done_reg;
  assign err_timeout  = err_reg;

endmodule

// File: tb/tb_mm_gelu_layer_sched.sv
// Self-checking bench for mm_gelu_layer_sched. A single-slice instance covers
// streaming, wrap, backpressure, watchdog and reset; a two-slice instance
// covers slice counting. Expected values come from a parameter-table model.
module tb_mm_gelu_layer_sched;

  localparam int DW = 32;
  localparam int NL = 12;

  logic        clk = 1'b0;
  logic        rst, start, start2;
  logic [3:0]  first_layer;
  logic [4:0]  num_layers;
  logic [31:0] timeout_limit;
  logic        cfg_we, cfg_sel;
  logic [3:0]  cfg_addr;
  logic [31:0] cfg_data;
  logic        m_ready, e_ready, res_tvalid, res_tlast;

  logic        m_valid, m_last, e_valid, e_last, busy, done, err;
  logic [31:0] m_data, e_data;
  logic [3:0]  layer;
  logic [0:0]  slice_cntr;

  logic        m_valid2, m_last2, e_valid2, e_last2, busy2, done2, err2;
  logic [31:0] m_data2, e_data2;
  logic [3:0]  layer2;
  logic [1:0]  slice_cntr2;

  int n_assert = 0;
  int n_fail   = 0;
  logic [31:0] m_ref [NL];
  logic [31:0] e_ref [NL];

  always #5 clk = ~clk;

  mm_gelu_layer_sched #(.D_W_ACC(DW), .LAYERS(NL), .SLICES(1), .TIMEOUT_W(32)) u_dut (
    .clk(clk), .rst(rst), .start(start), .first_layer(first_layer),
    .num_layers(num_layers), .timeout_limit(timeout_limit),
    .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .out_m_tvalid(m_valid), .out_m_tdata(m_data), .out_m_tlast(m_last), .out_m_tready(m_ready),
    .out_e_tvalid(e_valid), .out_e_tdata(e_data), .out_e_tlast(e_last), .out_e_tready(e_ready),
    .res_tvalid(res_tvalid), .res_tlast(res_tlast),
    .layer(layer), .slice_cntr(slice_cntr), .busy(busy), .done(done), .err_timeout(err)
  );

  mm_gelu_layer_sched #(.D_W_ACC(DW), .LAYERS(NL), .SLICES(2), .TIMEOUT_W(32)) u_dut2 (
    .clk(clk), .rst(rst), .start(start2), .first_layer(first_layer),
    .num_layers(num_layers), .timeout_limit(timeout_limit),
    .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .out_m_tvalid(m_valid2), .out_m_tdata(m_data2), .out_m_tlast(m_last2), .out_m_tready(m_ready),
    .out_e_tvalid(e_valid2), .out_e_tdata(e_data2), .out_e_tlast(e_last2), .out_e_tready(e_ready),
    .res_tvalid(res_tvalid), .res_tlast(res_tlast),
    .layer(layer2), .slice_cntr(slice_cntr2), .busy(busy2), .done(done2), .err_timeout(err2)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic sel, input int a, input logic [31:0] d);
    cfg_we = 1'b1; cfg_sel = sel; cfg_addr = 4'(a); cfg_data = d;
    step();
    cfg_we = 1'b0;
    if (sel) e_ref[a] = d; else m_ref[a] = d;
  endtask

  // One run on the single-slice instance, checked cycle by cycle against the
  // parameter table: layer sequence first, first+1, ... modulo NL.
  task automatic run1(input int first, input int num, input int limit,
                      input int rdy_mode, input int gap, input bit clash);
    int L, hold, cyc, g;
    bit got_m, got_e;
    logic [31:0] exp_m, exp_e;
    first_layer = 4'(first); num_layers = 5'(num); timeout_limit = limit;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("start_err_clear", err, 0);
    if (num == 0) begin
      chk("zero_done", done, 1);
      chk("zero_busy", busy, 0);
      step();
      chk("zero_done_pulse", done, 0);
      $display("run first=%0d num=0 -> immediate done", first);
      return;
    end
    chk("start_busy", busy, 1);
    chk("start_done", done, 0);
    L = first;
    for (int i = 0; i < num; i++) begin
      exp_m = m_ref[L];
      exp_e = e_ref[L];
      chk("entry_m_valid", m_valid, 0);
      chk("entry_e_valid", e_valid, 0);
      chk("entry_layer", layer, L);
      chk("entry_slice", slice_cntr, 0);
      chk("entry_done", done, 0);
      if (clash && i == 0) begin
        cfg_we = 1'b1; cfg_sel = 1'b0; cfg_addr = 4'(L); cfg_data = ~exp_m;
        m_ref[L] = ~exp_m;
      end
      res_tvalid = 1'b1; res_tlast = 1'b1;
      step();
      cfg_we = 1'b0;
      got_m = 1'b0; got_e = 1'b0; hold = 0; cyc = 0;
      while (!(got_m && got_e)) begin
        chk("load_m_valid", m_valid, !got_m);
        chk("load_e_valid", e_valid, !got_e);
        chk("load_m_last", m_last, !got_m);
        chk("load_e_last", e_last, !got_e);
        if (!got_m) chk("m_data", m_data, exp_m);
        if (!got_e) chk("e_data", e_data, exp_e);
        chk("load_layer", layer, L);
        chk("load_busy", busy, 1);
        chk("load_done", done, 0);
        case (rdy_mode)
          0:       begin m_ready = 1'b1; e_ready = 1'b1; end
          1:       begin m_ready = 1'($urandom_range(0, 1)); e_ready = 1'($urandom_range(0, 1)); end
          default: begin m_ready = (hold >= 5); e_ready = 1'b1; end
        endcase
        hold++;
        res_tvalid = 1'($urandom_range(0, 1));
        res_tlast  = 1'($urandom_range(0, 1));
        if (m_ready) got_m = 1'b1;
        if (e_ready) got_e = 1'b1;
        step();
        cyc++;
        if (cyc > 60) begin
          chk("load_hs_bound", cyc, 0);
          break;
        end
      end
      $display("layer %0d beats m=%0h e=%0h after %0d cycles", L, exp_m, exp_e, cyc);
      m_ready = 1'b1; e_ready = 1'b1;
      g = (gap < 0) ? $urandom_range(0, 4) : gap;
      for (int k = 0; k <= g; k++) begin
        chk("run_busy", busy, 1);
        chk("run_m_valid", m_valid, 0);
        chk("run_e_valid", e_valid, 0);
        chk("run_slice", slice_cntr, 0);
        chk("run_layer", layer, L);
        chk("run_done", done, 0);
        chk("run_err", err, 0);
        if (k < g) begin
          res_tvalid = 1'($urandom_range(0, 1));
          res_tlast  = res_tvalid ? 1'b0 : 1'($urandom_range(0, 1));
          start = ($urandom_range(0, 3) == 0);
          first_layer = 4'($urandom_range(0, NL - 1));
          num_layers = '0;
        end else begin
          res_tvalid = 1'b1; res_tlast = 1'b1;
        end
        step();
        start = 1'b0;
      end
      res_tvalid = 1'b0; res_tlast = 1'b0;
      L = (L + 1) % NL;
    end
    chk("end_done", done, 1);
    chk("end_busy", busy, 0);
    chk("end_err", err, 0);
    chk("end_m_valid", m_valid, 0);
    step();
    chk("done_pulse", done, 0);
    $display("run first=%0d num=%0d limit=%0d done", first, num, limit);
  endtask

  initial begin
    #500000;
    $display("FAIL global_time_limit reached");
    $fatal(1, "bench time limit");
  end

  initial begin
    int L;
    rst = 1'b1; start = 1'b0; start2 = 1'b0;
    first_layer = '0; num_layers = '0; timeout_limit = '0;
    cfg_we = 1'b0; cfg_sel = 1'b0; cfg_addr = '0; cfg_data = '0;
    m_ready = 1'b1; e_ready = 1'b1; res_tvalid = 1'b0; res_tlast = 1'b0;
    step(); step();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_e_valid", e_valid, 0);
    chk("rst_m_last", m_last, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_e_data", e_data, 0);
    chk("rst_layer", layer, 0);
    chk("rst_slice", slice_cntr, 0);
    chk("rst_busy2", busy2, 0);
    chk("rst_slice2", slice_cntr2, 0);
    $display("reset state checked");
    rst = 1'b0;
    step();

    for (int a = 0; a < NL; a++) begin
      cfg_write(1'b0, a, $urandom);
      cfg_write(1'b1, a, $urandom);
    end
    cfg_write(1'b0, 0, 10); cfg_write(1'b0, 1, 11); cfg_write(1'b0, 2, 12);
    cfg_write(1'b1, 0, 3);  cfg_write(1'b1, 1, 4);  cfg_write(1'b1, 2, 5);

    run1(0, 3, 0, 0, -1, 1'b0);     // basic three-layer run
    run1(11, 2, 1000, 0, 2, 1'b0);  // layer index wrap 11 -> 0
    run1(4, 1, 0, 2, 1, 1'b0);      // out_m held off for 5 cycles
    run1(7, 2, 4, 1, 3, 1'b1);      // completion at watchdog limit; write/load clash
    for (int r = 0; r < 8; r++) begin
      run1($urandom_range(0, NL - 1), $urandom_range(1, 4),
           ($urandom_range(0, 1) == 0) ? 0 : 1000, 1, -1, 1'b0);
    end

    // Watchdog expiry: 100 RUN cycles with no slice completion.
    first_layer = 4'd0; num_layers = 5'd2; timeout_limit = 100;
    start = 1'b1; step(); start = 1'b0;
    chk("to_entry", m_valid, 0);
    step();
    chk("to_valid", m_valid, 1);
    step();
    for (int k = 1; k <= 100; k++) begin
      chk("to_run_done", done, 0);
      chk("to_run_err", err, 0);
      step();
    end
    chk("to_done", done, 1);
    chk("to_err", err, 1);
    chk("to_busy", busy, 0);
    step();
    chk("to_err_sticky", err, 1);
    chk("to_done_pulse", done, 0);
    $display("watchdog expiry after 100 RUN cycles");
    run1(5, 0, 0, 0, 0, 1'b0);      // clears err, immediate done

    // Reset while running layer 1.
    first_layer = 4'd0; num_layers = 5'd3; timeout_limit = 0;
    start = 1'b1; step(); start = 1'b0;
    step(); step();
    res_tvalid = 1'b1; res_tlast = 1'b1; step(); res_tvalid = 1'b0; res_tlast = 1'b0;
    step(); step();
    chk("rst_pre_layer", layer, 1);
    chk("rst_pre_busy", busy, 1);
    rst = 1'b1; step(); rst = 1'b0;
    chk("midrst_busy", busy, 0);
    chk("midrst_layer", layer, 0);
    chk("midrst_m_valid", m_valid, 0);
    chk("midrst_e_valid", e_valid, 0);
    chk("midrst_done", done, 0);
    chk("midrst_m_data", m_data, 0);
    step();
    chk("midrst_done_after", done, 0);
    chk("midrst_busy_after", busy, 0);
    $display("mid-run reset checked");

    // Two slices per layer on the second instance.
    first_layer = 4'd2; num_layers = 5'd2; timeout_limit = 0;
    start2 = 1'b1; step(); start2 = 1'b0;
    for (int i = 0; i < 2; i++) begin
      L = 2 + i;
      chk("s2_entry_valid", m_valid2, 0);
      chk("s2_entry_layer", layer2, L);
      chk("s2_entry_slice", slice_cntr2, 0);
      res_tvalid = 1'b1; res_tlast = 1'b1;
      step();
      chk("s2_m_data", m_data2, m_ref[L]);
      chk("s2_e_data", e_data2, e_ref[L]);
      chk("s2_m_last", m_last2, 1);
      chk("s2_e_last", e_last2, 1);
      chk("s2_e_valid", e_valid2, 1);
      step();
      res_tvalid = 1'b0; res_tlast = 1'b0;
      chk("s2_run_slice0", slice_cntr2, 0);
      chk("s2_run_busy", busy2, 1);
      res_tvalid = 1'b1; res_tlast = 1'b1; step(); res_tvalid = 1'b0; res_tlast = 1'b0;
      chk("s2_slice1", slice_cntr2, 1);
      chk("s2_layer_hold", layer2, L);
      chk("s2_no_reload", m_valid2, 0);
      step();
      chk("s2_slice1_hold", slice_cntr2, 1);
      res_tvalid = 1'b1; res_tlast = 1'b1; step(); res_tvalid = 1'b0; res_tlast = 1'b0;
      $display("two-slice layer %0d complete", L);
    end
    chk("s2_done", done2, 1);
    chk("s2_busy", busy2, 0);
    chk("s2_err", err2, 0);
    chk("s2_slice_end", slice_cntr2, 0);
    step();
    chk("s2_done_pulse", done2, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
